// File: rtl/tone_seq_detector.sv
// tone_seq_detector: measures square-wave half-periods, qualifies 1/2/3/4 kHz tones and recognises the 1K-2K-3K-4K-silence chime
//   clk        system clock
//   rst        synchronous active-low reset
//   en         enable, low holds the block in its reset state
//   melody_in  asynchronous square-wave tone line
//   tone_id    0 = none/silence, 1..4 = qualified 1K..4K tone
//   tone_valid high while tone_id holds a qualified tone
//   silent     high while no edge has been seen for SILENCE_CYC cycles
//   detected   one-cycle pulse when the full chime is recognised
//   seq_err    one-cycle pulse on an out-of-order tone or early silence
module tone_seq_detector #(
  parameter int unsigned HALF_1K     = 50_000,
  parameter int unsigned HALF_2K     = 25_000,
  parameter int unsigned HALF_3K     = 16_667,
  parameter int unsigned HALF_4K     = 12_500,
  parameter int unsigned TOL_SHIFT   = 4,
  parameter int unsigned MIN_HALVES  = 8,
  parameter int unsigned SILENCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       melody_in,
  output logic [2:0] tone_id,
  output logic       tone_valid,
  output logic       silent,
  output logic       detected,
  output logic       seq_err
);
  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4} state_t;
  state_t state, state_n;
  logic s0, s1, s2, armed, tv_q, sil_q, det_n, err_n;
  logic clr, edge_w, smp, hit, qual;
  logic [31:0] hp, run, run_n, sample;
  logic [2:0] prev, cls;
  function automatic logic in_win(input logic [31:0] s, input logic [31:0] h);
    return (s + (h >> TOL_SHIFT) >= h) && (s <= h + (h >> TOL_SHIFT));
  endfunction
  assign clr    = !rst || !en;
  assign edge_w = s1 ^ s2;
  assign smp    = edge_w && armed;
  assign hit    = !edge_w && hp == SILENCE_CYC - 1;
  assign sample = hp + 32'd1;
  assign cls    = in_win(sample, HALF_1K) ? 3'd1 :
                  in_win(sample, HALF_2K) ? 3'd2 :
                  in_win(sample, HALF_3K) ? 3'd3 :
                  in_win(sample, HALF_4K) ? 3'd4 : 3'd0;
  assign run_n  = (cls != 3'd0 && cls == prev) ? ((run == MIN_HALVES) ? run : run + 32'd1)
                                               : {31'd0, cls != 3'd0};
  assign qual   = run_n == MIN_HALVES;
  always_ff @(posedge clk) begin
    if (clr) begin
      {s0, s1, s2} <= '0;
      hp           <= '0;
      armed        <= 1'b0;
      silent       <= 1'b1;
      tone_valid   <= 1'b0;
      tone_id      <= 3'd0;
      prev         <= 3'd0;
      run          <= '0;
      tv_q         <= 1'b0;
      sil_q        <= 1'b1;
      state        <= IDLE;
      detected     <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      s0       <= melody_in;
      s1       <= s0;
      s2       <= s1;
      hp       <= edge_w ? '0 : (hp == SILENCE_CYC) ? hp : hp + 32'd1;
      tv_q     <= tone_valid;
      sil_q    <= silent;
      state    <= state_n;
      detected <= det_n;
      seq_err  <= err_n;
      if (edge_w) begin
        armed  <= 1'b1;
        silent <= 1'b0;
      end
      if (smp) begin
        prev       <= cls;
        run        <= run_n;
        tone_valid <= qual;
        tone_id    <= qual ? cls : 3'd0;
      end else if (hit) begin
        armed      <= 1'b0;
        silent     <= 1'b1;
        tone_valid <= 1'b0;
        tone_id    <= 3'd0;
        prev       <= 3'd0;
        run        <= '0;
      end
    end
  end
  always_comb begin
    state_n = state;
    det_n   = 1'b0;
    err_n   = 1'b0;
    if (silent && !sil_q) begin
      state_n = IDLE;
      det_n   = state == S4;
      err_n   = state != IDLE && state != S4;
    end else if (tone_valid && !tv_q) begin
      if (state == IDLE) state_n = tone_id == 3'd1 ? S1 : IDLE;
      else if (tone_id == state) state_n = state;
      else if (state != S4 && tone_id == state + 3'd1) state_n = state_t'(state + 3'd1);
      else begin
        err_n   = 1'b1;
        state_n = tone_id == 3'd1 ? S1 : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_tone_seq_detector.sv
// tb_tone_seq_detector: randomized and directed self-checking bench for tone_seq_detector against a timestamp-based reference model
module tb_tone_seq_detector;
  localparam int H1 = 50, H2 = 25, H3 = 17, H4 = 13, TS = 3, MINH = 4, SIL = 200;
  localparam int HT [5] = '{0, H1, H2, H3, H4};
  logic clk = 1'b0, rst = 1'b0, en = 1'b1, mel = 1'b0;
  logic [2:0] tone_id;
  logic tone_valid, silent, detected, seq_err;
  int tests = 0, fails = 0, n = 0;
  bit hist [3] = '{0, 0, 0};
  int last_edge = 0, last_cls = 0, run = 0, e_id = 0, prog = 0;
  bit armed = 0, e_tv = 0, e_sil = 1, e_det = 0, e_err = 0, o_tv = 0, o_sil = 1;
  int det_cnt = 0, err_cnt = 0, both_cnt = 0, tog_n = 0, det_at = 0;
  bit seen_tv = 0, tv_d = 0;
  logic [31:0] seqlog = 0;
  tone_seq_detector #(
    .HALF_1K(H1), .HALF_2K(H2), .HALF_3K(H3), .HALF_4K(H4),
    .TOL_SHIFT(TS), .MIN_HALVES(MINH), .SILENCE_CYC(SIL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .melody_in(mel),
    .tone_id(tone_id), .tone_valid(tone_valid), .silent(silent),
    .detected(detected), .seq_err(seq_err)
  );
  always #5 clk = ~clk;
  function automatic int classify(input int s);
    for (int k = 1; k <= 4; k++)
      if ((s > HT[k] ? s - HT[k] : HT[k] - s) <= (HT[k] >> TS)) return k;
    return 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, n);
    end
  endtask
  task automatic model();
    bit ed;
    int c;
    if (!rst || !en) begin
      hist = '{0, 0, 0};
      last_edge = n; armed = 0; last_cls = 0; run = 0; prog = 0;
      e_id = 0; e_tv = 0; e_sil = 1; e_det = 0; e_err = 0; o_tv = 0; o_sil = 1;
    end else begin
      e_det = 0;
      e_err = 0;
      if (e_sil && !o_sil) begin
        if (prog == 4) e_det = 1;
        else if (prog != 0) e_err = 1;
        prog = 0;
      end else if (e_tv && !o_tv) begin
        if (prog == 0) prog = (e_id == 1) ? 1 : 0;
        else if (e_id != prog) begin
          if (prog < 4 && e_id == prog + 1) prog++;
          else begin
            e_err = 1;
            prog = (e_id == 1) ? 1 : 0;
          end
        end
      end
      o_tv = e_tv;
      o_sil = e_sil;
      ed = hist[1] != hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = mel;
      if (ed) begin
        if (armed) begin
          c = classify(n - last_edge);
          run = (c != 0 && c == last_cls) ? run + 1 : (c != 0 ? 1 : 0);
          last_cls = c;
          e_tv = run >= MINH;
          e_id = e_tv ? c : 0;
        end
        armed = 1;
        last_edge = n;
        e_sil = 0;
      end else if (n - last_edge == SIL) begin
        e_sil = 1; e_tv = 0; e_id = 0; armed = 0; last_cls = 0; run = 0;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    model();
    chk("tone_id", 32'(tone_id), 32'(e_id));
    chk("tone_valid", 32'(tone_valid), 32'(e_tv));
    chk("silent", 32'(silent), 32'(e_sil));
    chk("detected", 32'(detected), 32'(e_det));
    chk("seq_err", 32'(seq_err), 32'(e_err));
    det_cnt += int'(detected);
    err_cnt += int'(seq_err);
    if (detected && seq_err) both_cnt++;
    if (detected) det_at = n;
    if (tone_valid) seen_tv = 1;
    if (tone_valid && !tv_d) seqlog = (seqlog << 4) | 32'(tone_id);
    tv_d = tone_valid;
  endtask
  task automatic toggle();
    mel = !mel;
    tog_n = n + 1;
  endtask
  task automatic idle(input int c);
    repeat (c) tick();
  endtask
  task automatic half(input int c);
    toggle();
    repeat (c) tick();
  endtask
  task automatic tone(input int h, input int ncyc);
    int cur = h, k = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (k >= cur) begin
        toggle();
        k = 0;
        cur = h + int'($urandom_range(0, 2)) - 1;
      end
      tick();
      k++;
    end
  endtask
  task automatic chime();
    tone(H1, 700); tone(H2, 700); tone(H3, 700); tone(H4, 700); idle(300);
  endtask
  initial begin
    int d0, e0, h;
    for (int i = 0; i < 5; i++) begin
      mel = !mel;
      tick();
    end
    chk("rst_tone_id", 32'(tone_id), 32'd0);
    chk("rst_silent", 32'(silent), 32'd1);
    chk("rst_pulses", 32'(detected | seq_err), 32'd0);
    rst = 1'b1;
    mel = 1'b0;
    idle(10);
    chk("silent_hold", 32'(silent), 32'd1);
    toggle();
    idle(3);
    chk("silent_clear", 32'(silent), 32'd0);
    idle(300);
    d0 = det_cnt; e0 = err_cnt; seqlog = 0;
    chime();
    chk("chime_det", 32'(det_cnt - d0), 32'd1);
    chk("chime_err", 32'(err_cnt - e0), 32'd0);
    chk("chime_order", seqlog, 32'h1234);
    chk("det_delay", 32'(det_at - tog_n), 32'd203);
    seen_tv = 0;
    repeat (5) begin half(43); half(57); end
    chk("tol_reject", 32'(seen_tv), 32'd0);
    idle(300);
    repeat (5) begin half(44); half(56); end
    idle(300);
    half(47); half(53); half(47); half(53);
    chk("tol_3_samples", 32'(tone_valid), 32'd0);
    half(47);
    chk("tol_4_samples_id", 32'(tone_id), 32'd1);
    chk("tol_4_samples_v", 32'(tone_valid), 32'd1);
    idle(300);
    d0 = det_cnt; e0 = err_cnt;
    tone(H1, 400); tone(H3, 400);
    chk("ooo_err", 32'(err_cnt - e0), 32'd1);
    idle(300);
    chk("ooo_no_det", 32'(det_cnt - d0), 32'd0);
    chk("ooo_silence_err", 32'(err_cnt - e0), 32'd1);
    d0 = det_cnt; e0 = err_cnt;
    tone(H1, 400); tone(H2, 400); idle(300);
    chk("early_sil_err", 32'(err_cnt - e0), 32'd1);
    chk("early_sil_det", 32'(det_cnt - d0), 32'd0);
    d0 = det_cnt; e0 = err_cnt;
    chime();
    chk("recover_det", 32'(det_cnt - d0), 32'd1);
    chk("recover_err", 32'(err_cnt - e0), 32'd0);
    d0 = det_cnt; e0 = err_cnt;
    tone(H1, 400); tone(H2, 400); tone(H3, 300);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tone(H3, 400); tone(H4, 700); idle(300);
    chk("midrst_det", 32'(det_cnt - d0), 32'd0);
    chk("midrst_err", 32'(err_cnt - e0), 32'd0);
    tone(H1, 400);
    chk("en_pre_valid", 32'(tone_valid), 32'd1);
    en = 1'b0;
    tick();
    chk("en_tone_id", 32'(tone_id), 32'd0);
    chk("en_tone_valid", 32'(tone_valid), 32'd0);
    chk("en_silent", 32'(silent), 32'd1);
    en = 1'b1;
    idle(300);
    for (int s = 0; s < 30; s++) begin
      h = int'($urandom_range(0, 5));
      if (h < 4) tone(HT[h + 1], int'($urandom_range(100, 400)));
      else if (h == 4) tone(int'($urandom_range(5, 70)), int'($urandom_range(100, 300)));
      else idle(int'($urandom_range(150, 260)));
      if ($urandom_range(0, 7) == 0) begin
        en = 1'b0;
        tick();
        en = 1'b1;
      end
    end
    chime();
    chk("no_overlap", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
